// File: rtl/tinyriscv_pkg.sv
// Shared types and helpers for the multi-port integer register file.
// Optional parity storage is enabled with the REGFILE_PARITY_EN macro.
package tinyriscv_pkg;

  typedef enum logic {RF_CLEAR, RF_READY} rf_state_e;

  localparam int RF_MAX_RD     = 4;
  localparam int RF_MAX_WR     = 2;
  localparam int RF_MAX_DATA_W = 64;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic rf_parity(input logic [RF_MAX_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: allocate sets, accepted writeback clears, flush empties.
module regfile_scoreboard
  import tinyriscv_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     set_i,
  input  logic [ADDR_W-1:0]        set_addr_i,
  input  logic [NUM_WR-1:0]        clr_i,
  input  logic [NUM_WR*ADDR_W-1:0] clr_addr_i,
  input  logic [NUM_RD-1:0]        re_i,
  input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
  output logic [NUM_RD-1:0]        busy_o
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Set is applied after the clears so an allocate beats a same-cycle writeback.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      if (clr_i[j]) busy_d[clr_addr_i[j*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (set_i) busy_d[set_addr_i] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else if (flush_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    busy_o = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      busy_o[k] = busy_q[raddr_i[k*ADDR_W +: ADDR_W]] & re_i[k];
      if ((ZERO_REG != 0) && (raddr_i[k*ADDR_W +: ADDR_W] == '0)) busy_o[k] = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write priority, bypass, busy scoreboard and a sweep-clear FSM.
// Define REGFILE_PARITY_EN to store and check one even-parity bit per entry.
module regfile_mp
  import tinyriscv_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_req_i,
  output logic                     ready_o,
  input  logic [NUM_WR-1:0]        we_i,
  input  logic [NUM_WR*ADDR_W-1:0] waddr_i,
  input  logic [NUM_WR*DATA_W-1:0] wdata_i,
  input  logic [NUM_RD-1:0]        re_i,
  input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
  output logic [NUM_RD*DATA_W-1:0] rdata_o,
  output logic [NUM_RD-1:0]        busy_o,
  input  logic                     alloc_i,
  input  logic [ADDR_W-1:0]        alloc_addr_i,
  output logic [NUM_RD-1:0]        par_err_o,
  output logic                     par_err_sticky_o
);

  localparam int DEPTH = 2**ADDR_W;

  if (NUM_RD < 1 || NUM_RD > RF_MAX_RD) begin : g_bad_rd
    $error("regfile_mp: NUM_RD out of range");
  end
  if (NUM_WR < 1 || NUM_WR > RF_MAX_WR) begin : g_bad_wr
    $error("regfile_mp: NUM_WR out of range");
  end
  if (DATA_W > RF_MAX_DATA_W) begin : g_bad_dw
    $error("regfile_mp: DATA_W too wide");
  end

  rf_state_e         state;
  logic [ADDR_W-1:0] ptr;
  logic              ready;

  logic [ADDR_W-1:0] waddr [NUM_WR];
  logic [DATA_W-1:0] wdata [NUM_WR];
  logic [ADDR_W-1:0] raddr [NUM_RD];
  logic [NUM_WR-1:0] we_acc;

  logic [DATA_W-1:0] mem [DEPTH];
`ifdef REGFILE_PARITY_EN
  logic              par_mem [DEPTH];
  logic [NUM_RD-1:0] rd_par_err;
  logic              sticky_q;
`endif

  assign ready   = (state == RF_READY);
  assign ready_o = ready;

  always_comb begin
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      waddr[j] = waddr_i[j*ADDR_W +: ADDR_W];
      wdata[j] = wdata_i[j*DATA_W +: DATA_W];
    end
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      raddr[k] = raddr_i[k*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    we_acc = '0;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      we_acc[j] = ready && we_i[j] && !((ZERO_REG != 0) && (waddr[j] == '0));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= RF_CLEAR;
      ptr   <= '0;
    end else if (clear_req_i) begin
      state <= RF_CLEAR;
      ptr   <= '0;
    end else if (state == RF_CLEAR) begin
      ptr <= ptr + 1'b1;
      if (ptr == ADDR_W'(DEPTH-1)) state <= RF_READY;
    end
  end

  // No reset on the array: the sweep zeroes one entry per cycle until ready.
  // Ascending port loop lets the highest-index port win on an address collision.
  always_ff @(posedge clk_i) begin
    if (!ready) begin
      mem[ptr] <= '0;
`ifdef REGFILE_PARITY_EN
      par_mem[ptr] <= 1'b0;
`endif
    end else begin
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (we_acc[j]) begin
          mem[waddr[j]] <= wdata[j];
`ifdef REGFILE_PARITY_EN
          par_mem[waddr[j]] <= rf_parity(RF_MAX_DATA_W'(wdata[j]));
`endif
        end
      end
    end
  end

  always_comb begin
    logic              hit;
    logic [DATA_W-1:0] val;
    rdata_o = '0;
`ifdef REGFILE_PARITY_EN
    rd_par_err = '0;
`endif
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      hit = 1'b0;
      val = '0;
      if (ready && re_i[k] && !((ZERO_REG != 0) && (raddr[k] == '0))) begin
        for (int unsigned j = 0; j < NUM_WR; j++) begin
          if ((BYPASS != 0) && we_i[j] && (waddr[j] == raddr[k])) begin
            hit = 1'b1;
            val = wdata[j];
          end
        end
        if (!hit) begin
          val = mem[raddr[k]];
`ifdef REGFILE_PARITY_EN
          rd_par_err[k] = rf_parity(RF_MAX_DATA_W'(val)) != par_mem[raddr[k]];
`endif
        end
      end
      rdata_o[k*DATA_W +: DATA_W] = val;
    end
  end

`ifdef REGFILE_PARITY_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sticky_q <= 1'b0;
    end else if (clear_req_i) begin
      sticky_q <= 1'b0;
    end else if (|rd_par_err) begin
      sticky_q <= 1'b1;
    end
  end

  assign par_err_o        = rd_par_err;
  assign par_err_sticky_o = sticky_q;
`else
  assign par_err_o        = '0;
  assign par_err_sticky_o = 1'b0;
`endif

  logic [NUM_RD-1:0] sb_busy;

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (clear_req_i),
    .set_i      (ready && alloc_i),
    .set_addr_i (alloc_addr_i),
    .clr_i      (we_acc),
    .clr_addr_i (waddr_i),
    .re_i       (re_i),
    .raddr_i    (raddr_i),
    .busy_o     (sb_busy)
  );

  assign busy_o = ready ? sb_busy : '0;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (2 read ports, 2 write ports).
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_req;
  logic        ready;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  busy;
  logic        alloc;
  logic [4:0]  alloc_addr;
  logic [1:0]  par_err;
  logic        par_sticky;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  regfile_mp #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .NUM_RD   (2),
    .NUM_WR   (2),
    .ZERO_REG (1),
    .BYPASS   (1)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .clear_req_i      (clear_req),
    .ready_o          (ready),
    .we_i             (we),
    .waddr_i          (waddr),
    .wdata_i          (wdata),
    .re_i             (re),
    .raddr_i          (raddr),
    .rdata_o          (rdata),
    .busy_o           (busy),
    .alloc_i          (alloc),
    .alloc_addr_i     (alloc_addr),
    .par_err_o        (par_err),
    .par_err_sticky_o (par_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear_req = 1'b0; we = '0; waddr = '0; wdata = '0;
    re = '0; raddr = '0; alloc = 1'b0; alloc_addr = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #22;
    chk("rst_ready", {63'd0, ready}, 64'd0);
    chk("rst_busy", {62'd0, busy}, 64'd0);
    rst = 1'b0;

    // Sweep after reset: ready rises on the 32nd edge.
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i == 31 || i == 32) chk($sformatf("sweep_ready_%0d", i), {63'd0, ready}, (i == 32) ? 64'd1 : 64'd0);
      if (i == 10) begin
        re = 2'b11; raddr = {5'd1, 5'd2};
        #1 chk("sweep_rdata", rdata, 64'd0);
        re = '0;
      end
    end
    re = 2'b11; raddr = {5'd1, 5'd2};
    #1 chk("ready_rdata_zero", rdata, 64'd0);
    re = '0;

    // Single write then read on both ports; x0 stays zero.
    we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'd0, 32'hDEADBEEF};
    tick();
    idle();
    re = 2'b11; raddr = {5'd5, 5'd5};
    #1 chk("x5_both", rdata, {32'hDEADBEEF, 32'hDEADBEEF});
    raddr = {5'd5, 5'd0};
    #1 chk("x0_read", rdata, {32'hDEADBEEF, 32'h0});

    // Write to x0 is dropped and not bypassed.
    we = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'd0, 32'hFFFF_FFFF};
    re = 2'b01; raddr = {5'd0, 5'd0};
    #1 chk("x0_bypass", rdata, 64'd0);
    tick();
    idle();
    re = 2'b01;
    #1 chk("x0_after_write", rdata, 64'd0);

    // Port collision: port 1 wins for bypass and storage.
    we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h22, 32'h11};
    re = 2'b01; raddr = {5'd0, 5'd7};
    #1 chk("x7_bypass", rdata, {32'h0, 32'h22});
    tick();
    idle();
    re = 2'b10; raddr = {5'd7, 5'd0};
    #1 chk("x7_stored", rdata, {32'h22, 32'h0});

    // Scoreboard.
    alloc = 1'b1; alloc_addr = 5'd9;
    re = 2'b01; raddr = {5'd0, 5'd9};
    #1 chk("x9_busy_pre", {62'd0, busy}, 64'd0);
    tick();
    alloc = 1'b0;
    #1 chk("x9_busy", {62'd0, busy}, 64'd1);
    re = 2'b00;
    #1 chk("x9_busy_re0", {62'd0, busy}, 64'd0);
    re = 2'b11; raddr = {5'd9, 5'd9};
    alloc = 1'b1; we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'd0, 32'h99};
    #1 chk("x9_busy_same_cyc", {62'd0, busy}, 64'd3);
    tick();
    idle();
    re = 2'b01; raddr = {5'd0, 5'd9};
    #1 chk("x9_set_wins", {62'd0, busy}, 64'd1);
    we = 2'b10; waddr = {5'd9, 5'd0}; wdata = {32'h9A, 32'd0};
    tick();
    idle();
    re = 2'b01; raddr = {5'd0, 5'd9};
    #1 chk("x9_cleared", {62'd0, busy}, 64'd0);
    alloc = 1'b1; alloc_addr = 5'd0;
    tick();
    idle();
    re = 2'b01; raddr = '0;
    #1 chk("x0_never_busy", {62'd0, busy}, 64'd0);

    // Clear request restarts the sweep and flushes busy bits.
    we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'd0, 32'h5};
    alloc = 1'b1; alloc_addr = 5'd10;
    tick();
    idle();
    re = 2'b11; raddr = {5'd10, 5'd3};
    #1 chk("x3_before_clear", rdata[31:0], 64'h5);
    chk("x10_busy_before_clear", {62'd0, busy}, 64'd2);
    re = '0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("clear_ready_drop", {63'd0, ready}, 64'd0);
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i == 31 || i == 32) chk($sformatf("clear_ready_%0d", i), {63'd0, ready}, (i == 32) ? 64'd1 : 64'd0);
    end
    re = 2'b11; raddr = {5'd10, 5'd3};
    #1 chk("x3_after_clear", rdata, 64'd0);
    chk("busy_after_clear", {62'd0, busy}, 64'd0);

`ifdef REGFILE_PARITY_EN
    idle();
    we = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'd0, 32'h1};
    tick();
    idle();
    dut.par_mem[4] = ~dut.par_mem[4];
    re = 2'b01; raddr = {5'd0, 5'd4};
    #1 chk("par_err", {62'd0, par_err}, 64'd1);
    tick();
    re = '0;
    #1 chk("par_sticky_set", {63'd0, par_sticky}, 64'd1);
    tick();
    chk("par_sticky_hold", {63'd0, par_sticky}, 64'd1);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("par_sticky_clr", {63'd0, par_sticky}, 64'd0);
`else
    chk("par_err_off", {61'd0, par_sticky, par_err}, 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
